// File: rtl/jtvigil_pkg.sv
// Shared types and constants for the parametrised scroll-layer tile fetcher.
package jtvigil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP,
    ST_CODE,
    ST_ROM,
    ST_WR
  } fetch_st_e;

  localparam int TILE_W   = 8;
  localparam int BPP      = 4;
  localparam int LBUF_LEN = 512;
  localparam int FILLW    = 10;   // holds 0..LBUF_LEN

  // Colour of pixel p (0 = leftmost) in a packed 8-pixel ROM word.
  function automatic logic [BPP-1:0] tile_pixel(input logic [31:0] word,
                                                input logic [2:0]  p,
                                                input logic        hflip);
    logic [2:0] idx;
    idx = hflip ? ~p : p;
    return word[idx*BPP +: BPP];
  endfunction

endpackage

// File: rtl/jtvigil_linebuf.sv
// Double line buffer: the back half is written by the fetcher while the front half
// plays out; a per-half fill limit masks pixels that were never written this line.
module jtvigil_linebuf
  import jtvigil_pkg::*;
#(
  parameter int DW   = 7,
  parameter int HLEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             swap,
  input  logic             we,
  input  logic [8:0]       waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [FILLW-1:0] wfill,
  input  logic             rd_cen,
  input  logic [8:0]       raddr,
  output logic [DW-1:0]    rdata
);

  logic                  sel;
  logic [1:0][FILLW-1:0] fill;
  logic [DW-1:0]         mem [0:2*LBUF_LEN-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel  <= 1'b0;
      fill <= '0;
    end else if (swap) begin
      sel       <= ~sel;
      fill[sel] <= '0;    // old front becomes the new back half
    end else if (we) begin
      fill[~sel] <= wfill;
    end
  end

  // NOTE: the storage array is deliberately not reset; stale contents are
  // hidden by the fill limit, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (we && !swap) mem[{~sel, waddr}] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_cen) begin
      if (FILLW'(raddr) >= FILLW'(HLEN) || FILLW'(raddr) >= fill[sel])
        rdata <= '0;
      else
        rdata <= mem[{sel, raddr}];
    end
  end

endmodule

// File: rtl/jtvigil_tilefetch.sv
// Scroll-layer engine: during line v fetches tilemap entries and 4bpp tile rows for
// line v+1 into the back line buffer while the front buffer is played out on pxl_cen.
module jtvigil_tilefetch
  import jtvigil_pkg::*;
#(
  parameter int SCRW  = 9,
  parameter int MAPCW = 6,
  parameter int MAPRW = 5,
  parameter int CODEW = 12,
  parameter int PALW  = 3,
  parameter int HLEN  = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pxl_cen,
  input  logic                   hinit,
  input  logic [8:0]             h,
  input  logic [8:0]             v,
  input  logic [SCRW-1:0]        scrpos,
  output logic [MAPRW+MAPCW-1:0] vram_addr,
  input  logic [15:0]            vram_data,
  output logic [CODEW+2:0]       rom_addr,
  output logic                   rom_cs,
  input  logic                   rom_ok,
  input  logic [31:0]            rom_data,
  output logic [PALW+3:0]        pxl
);

  localparam int NTILES = HLEN/TILE_W + 1;   // one extra tile covers fine scroll
  localparam int TW     = $clog2(NTILES);
  localparam int XW     = 11;

  fetch_st_e state, nx_state;

  logic [SCRW-1:0]        scr;
  logic [8:0]             vf;
  logic [TW-1:0]          t;
  logic [2:0]             p;
  logic                   hflip;
  logic [PALW-1:0]        pal;
  logic [31:0]            word;
  logic                   rom_first;

  logic                   last_tile, accept;
  logic [SCRW-1:0]        map_scr;
  logic [8:0]             map_vf;
  logic [TW-1:0]          map_t;
  logic [MAPRW+MAPCW-1:0] map_addr;
  logic [XW-1:0]          pos, fine, xpos;
  logic                   in_line, we;
  logic [FILLW-1:0]       wfill;
  logic [PALW+3:0]        wdata;

  assign last_tile = (t == TW'(NTILES-1));
  // The first request cycle may still see rom_ok left over from a previous access.
  assign accept    = rom_ok && !rom_first;

  // Tilemap address of the tile about to be fetched: t=0 at line start, else t+1.
  always_comb begin
    map_scr  = hinit ? scrpos : scr;
    map_vf   = hinit ? v + 9'd1 : vf;
    map_t    = hinit ? '0 : t + TW'(1);
    map_addr = {MAPRW'(map_vf >> 3), MAPCW'(map_scr >> 3) + MAPCW'(map_t)};
  end

  // Screen column of the pixel being written; out-of-line pixels are dropped.
  always_comb begin
    pos     = XW'({t, p});
    fine    = XW'(scr[2:0]);
    xpos    = pos - fine;
    in_line = (pos >= fine) && (xpos < XW'(HLEN));
    we      = (state == ST_WR) && !hinit && in_line;
    wfill   = FILLW'(xpos + XW'(1));
    wdata   = {pal, tile_pixel(word, p, hflip)};
  end

  // NOTE: next state is defaulted to the current state before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nx_state = state;
    case (state)
      ST_IDLE: nx_state = ST_IDLE;
      ST_MAP:  nx_state = ST_CODE;
      ST_CODE: nx_state = ST_ROM;
      ST_ROM:  if (accept) nx_state = ST_WR;
      ST_WR:   if (p == 3'd7) nx_state = last_tile ? ST_IDLE : ST_MAP;
      default: nx_state = ST_IDLE;
    endcase
    if (hinit) nx_state = ST_MAP;   // line start aborts whatever is in flight
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      scr       <= '0;
      vf        <= '0;
      t         <= '0;
      p         <= '0;
      hflip     <= 1'b0;
      pal       <= '0;
      word      <= '0;
      rom_first <= 1'b0;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      vram_addr <= '0;
    end else begin
      state <= nx_state;
      if (hinit) begin
        scr       <= scrpos;
        vf        <= v + 9'd1;
        t         <= '0;
        rom_cs    <= 1'b0;
        vram_addr <= map_addr;
      end else begin
        case (state)
          ST_CODE: begin
            hflip     <= vram_data[CODEW+PALW];
            pal       <= vram_data[CODEW +: PALW];
            rom_addr  <= {vram_data[CODEW-1:0], vf[2:0]};
            rom_cs    <= 1'b1;
            rom_first <= 1'b1;
          end
          ST_ROM: begin
            rom_first <= 1'b0;
            if (accept) begin
              word   <= rom_data;
              rom_cs <= 1'b0;
              p      <= '0;
            end
          end
          ST_WR: begin
            p <= p + 3'd1;
            if (p == 3'd7 && !last_tile) begin
              t         <= t + TW'(1);
              vram_addr <= map_addr;
            end
          end
          default: ;
        endcase
      end
    end
  end

  jtvigil_linebuf #(
    .DW   (PALW+4),
    .HLEN (HLEN)
  ) u_linebuf (
    .clk    (clk),
    .rst    (rst),
    .swap   (hinit),
    .we     (we),
    .waddr  (xpos[8:0]),
    .wdata  (wdata),
    .wfill  (wfill),
    .rd_cen (pxl_cen),
    .raddr  (h),
    .rdata  (pxl)
  );

endmodule

// File: tb/tb_jtvigil_tilefetch.sv
// Self-checking bench for jtvigil_tilefetch: directed vector table, hand-written
// stall/reset sequences and randomised lines against a pixel-level reference model.
module tb_jtvigil_tilefetch;

  localparam int HLEN      = 256;
  localparam int NTILES    = HLEN/8 + 1;
  localparam int LINE_CLKS = 600;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, hinit;
  logic [8:0]  h, v, scrpos;
  logic [10:0] vram_addr;
  logic [15:0] vram_data;
  logic [14:0] rom_addr;
  logic        rom_cs, rom_ok;
  logic [31:0] rom_data;
  logic [6:0]  pxl;

  always #5 clk = ~clk;

  jtvigil_tilefetch dut (
    .clk       (clk),
    .rst       (rst),
    .pxl_cen   (pxl_cen),
    .hinit     (hinit),
    .h         (h),
    .v         (v),
    .scrpos    (scrpos),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_ok    (rom_ok),
    .rom_data  (rom_data),
    .pxl       (pxl)
  );

  logic [15:0] vram [2048];
  logic [31:0] rom  [32768];
  logic [6:0]  cap  [512];

  int n_cmp = 0;
  int n_err = 0;

  // ROM slot behaviour controls
  int lat      = 2;
  int stall_at = -1;
  bit stale_ok = 1'b0;

  int cnt = 0, nserved = 0, unstable = 0, rises = 0;
  bit served_flag = 1'b0;
  logic        rom_cs_q = 1'b0;
  logic [14:0] rom_addr_q = '0;

  always @(posedge clk) vram_data <= vram[vram_addr];

  always @(posedge clk) begin
    if (!rom_cs) begin
      cnt         <= 0;
      served_flag <= 1'b0;
      rom_ok      <= stale_ok;
      rom_data    <= 32'hdeadbeef;
    end else if (!served_flag && cnt + 1 >= lat && !(stall_at >= 0 && nserved >= stall_at)) begin
      cnt         <= cnt + 1;
      served_flag <= 1'b1;
      nserved     <= nserved + 1;
      rom_ok      <= 1'b1;
      rom_data    <= rom[rom_addr];
    end else begin
      cnt      <= cnt + 1;
      rom_ok   <= 1'b0;
      rom_data <= 32'hdeadbeef;
    end
    if (hinit) nserved <= 0;
  end

  always @(posedge clk) begin
    rom_cs_q   <= rom_cs;
    rom_addr_q <= rom_addr;
    if (rom_cs && rom_cs_q && rom_addr !== rom_addr_q) unstable <= unstable + 1;
    if (rom_cs && !rom_cs_q) rises <= rises + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pixel shown at screen column x for a line fetched with (vv, ss) when only the
  // first `done` tiles reached the buffer. Works in world coordinates.
  function automatic logic [6:0] model_pix(input int vv, input int ss, input int x, input int done);
    int vf, wx, p, pp, col, row;
    logic [15:0] e;
    logic [31:0] w;
    if (x >= HLEN) return 7'h0;
    vf = (vv + 1) % 512;
    wx = ss + x;
    if (((ss % 8) + x) / 8 >= done) return 7'h0;
    col = (wx / 8) % 64;
    row = (vf / 8) % 32;
    p   = wx % 8;
    e   = vram[row*64 + col];
    w   = rom[{e[11:0], 3'(vf % 8)}];
    pp  = e[15] ? 7 - p : p;
    return {e[14:12], 4'((w >> (4*pp)) & 32'hf)};
  endfunction

  task automatic start_line(input int vv, input int ss);
    @(negedge clk);
    hinit = 1'b1; v = 9'(vv); scrpos = 9'(ss); h = 9'd511;
    @(negedge clk);
    hinit = 1'b0;
  endtask

  task automatic finish_line();
    for (int i = 0; i < LINE_CLKS; i++) begin
      h = (i < 512) ? 9'(i) : 9'd511;
      @(negedge clk);
      if (i < 512) cap[i] = pxl;
    end
  endtask

  task automatic run_line(input int vv, input int ss);
    start_line(vv, ss);
    finish_line();
  endtask

  task automatic check_line(input string name, input int vv, input int ss, input int done);
    int bi;
    bi = -1;
    for (int x = 0; x < 512; x++)
      if (bi < 0 && cap[x] !== model_pix(vv, ss, x, done)) bi = x;
    if (bi < 0) bi = 0;
    check($sformatf("%s v=%0d scr=%0d h=%0d", name, vv, ss, bi), 32'(cap[bi]),
          32'(model_pix(vv, ss, bi, done)));
  endtask

  typedef struct {
    int         v;
    int         scr;
    int         h;
    logic [6:0] exp;
  } vec_t;

  vec_t tab [15];

  initial begin
    int pv, ps, nz, r0, budget;

    for (int i = 0; i < 2048; i++)  vram[i] = 16'($urandom);
    for (int i = 0; i < 32768; i++) rom[i]  = $urandom;
    vram[1*64 + 0]  = {1'b0, 3'd5, 12'h123};
    vram[1*64 + 1]  = {1'b0, 3'd2, 12'h456};
    vram[2*64 + 0]  = {1'b1, 3'd5, 12'h123};
    vram[0*64 + 63] = {1'b0, 3'd3, 12'h0aa};
    vram[0*64 + 0]  = {1'b0, 3'd4, 12'h0bb};
    rom[{12'h123, 3'd0}] = 32'h76543210;
    rom[{12'h456, 3'd0}] = 32'hfedcba98;
    rom[{12'h0aa, 3'd0}] = 32'h11111111;
    rom[{12'h0bb, 3'd0}] = 32'h22222222;

    tab[0]  = '{v:7,   scr:0,   h:0,   exp:7'h50};
    tab[1]  = '{v:7,   scr:0,   h:3,   exp:7'h53};
    tab[2]  = '{v:7,   scr:0,   h:7,   exp:7'h57};
    tab[3]  = '{v:7,   scr:0,   h:8,   exp:7'h28};
    tab[4]  = '{v:7,   scr:0,   h:256, exp:7'h00};
    tab[5]  = '{v:7,   scr:0,   h:300, exp:7'h00};
    tab[6]  = '{v:7,   scr:3,   h:0,   exp:7'h53};
    tab[7]  = '{v:7,   scr:3,   h:4,   exp:7'h57};
    tab[8]  = '{v:7,   scr:3,   h:5,   exp:7'h28};
    tab[9]  = '{v:15,  scr:0,   h:0,   exp:7'h57};
    tab[10] = '{v:15,  scr:0,   h:7,   exp:7'h50};
    tab[11] = '{v:255, scr:504, h:0,   exp:7'h31};
    tab[12] = '{v:255, scr:504, h:7,   exp:7'h31};
    tab[13] = '{v:255, scr:504, h:8,   exp:7'h42};
    tab[14] = '{v:255, scr:504, h:0,   exp:7'h31};

    rst = 1'b1; pxl_cen = 1'b1; hinit = 1'b0; h = '0; v = '0; scrpos = '0;
    repeat (4) @(negedge clk);
    check("reset rom_cs", 32'(rom_cs), 32'd0);
    check("reset rom_addr", 32'(rom_addr), 32'd0);
    check("reset vram_addr", 32'(vram_addr), 32'd0);
    check("reset pxl", 32'(pxl), 32'd0);
    rst = 1'b0;

    // First transaction: map address in MAP, then ROM address for the tile row
    start_line(7, 0);
    check("first vram_addr", 32'(vram_addr), 32'h040);
    budget = 0;
    while (!rom_cs && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) check("rom_cs timeout", 32'(rom_cs), 32'd1);
    else check("first rom_addr", 32'(rom_addr), 32'({12'h123, 3'd0}));
    finish_line();

    for (int i = 0; i <= 15; i++) begin
      if (i < 15) run_line(tab[i].v, tab[i].scr);
      else run_line(0, 0);
      if (i > 0)
        check($sformatf("vec%0d h=%0d", i-1, tab[i-1].h), 32'(cap[tab[i-1].h]), 32'(tab[i-1].exp));
    end

    // pxl only advances on pxl_cen; front buffer now holds the wrap line
    pxl_cen = 1'b0; h = 9'd0;
    repeat (2) @(negedge clk);
    check("pxl_cen hold", 32'(pxl), 32'd0);
    pxl_cen = 1'b1;
    @(negedge clk);
    check("pxl_cen read", 32'(pxl), 32'h31);
    pv = 0; ps = 0;

    // ROM stall after tile 10: request held, line truncated at h=80
    stall_at = 10;
    run_line(7, 0);
    check_line("pre-stall", pv, ps, NTILES);
    check("stall rom_cs", 32'(rom_cs), 32'd1);
    check("stall rom_addr", 32'(rom_addr), 32'({vram[1*64 + 10][11:0], 3'd0}));
    stall_at = -1;
    run_line(7, 3);
    check_line("stalled line", 7, 0, 10);
    check("stall h=79", 32'(cap[79]), 32'(model_pix(7, 0, 79, NTILES)));
    check("stall h=80", 32'(cap[80]), 32'd0);
    pv = 7; ps = 3;

    // Reset while waiting on ROM
    stall_at = 5;
    start_line(9, 40);
    repeat (150) @(negedge clk);
    check("pre-rst rom_cs", 32'(rom_cs), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst rom_cs", 32'(rom_cs), 32'd0);
    check("rst pxl", 32'(pxl), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    rst = 1'b0;
    stall_at = -1;
    r0 = rises; nz = 0;
    for (int i = 0; i < 300; i++) begin
      h = 9'(i);
      @(negedge clk);
      if (pxl !== 7'h0) nz++;
    end
    check("idle after rst nonzero pxl", 32'(nz), 32'd0);
    check("idle after rst rom requests", 32'(rises - r0), 32'd0);
    run_line(20, 100);
    check_line("post-rst empty", 0, 0, 0);
    pv = 20; ps = 100;

    // Randomised lines: scroll, line, ROM latency and stale rom_ok
    for (int k = 0; k < 24; k++) begin
      int vv, ss;
      vv = $urandom_range(0, 511);
      ss = $urandom_range(0, 511);
      lat = $urandom_range(1, 4);
      stale_ok = 1'($urandom_range(0, 1));
      run_line(vv, ss);
      check_line("rand", pv, ps, NTILES);
      pv = vv; ps = ss;
    end
    lat = 2; stale_ok = 1'b0;
    run_line(0, 0);
    check_line("rand last", pv, ps, NTILES);

    check("rom_addr stable while rom_cs", 32'(unstable), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
